bus_mux_onehot_reg: RTL and testbench

- Parametrised, registered successor to the datapath's one-hot bus multiplexer.
- Selects one of NSRC WIDTH-bit sources (DIN, G, R0..Rn) onto the shared CPU bus under a one-hot select from the control FSM.
- Captures the result into a bus register on a load strobe.
- Detects illegal selects (all-zero or multi-hot) and reports them through a sticky error flag, so the control unit and bench can catch decode faults instead of silently defaulting.

---
 rtl/bus_mux_onehot_reg.sv | 116 +++++++++++
 tb/tb_bus_mux_onehot_reg.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mux_onehot_reg.sv
// Registered one-hot bus multiplexer with sticky illegal-select detection.
// Define BUS_MUX_ERR_CNT_EN to add the saturating illegal-select counter output err_cnt.
`timescale 1ns/1ps
module bus_mux_onehot_reg #(
   parameter int WIDTH       = 9,
   parameter int NSRC        = 10,
   parameter int DEFAULT_IDX = 0,
   parameter int ERR_CNT_W   = 8,
   localparam int IDXW       = (NSRC > 2) ? $clog2(NSRC) : 1
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [WIDTH*NSRC-1:0] src_flat,
   input  logic [NSRC-1:0]       sel,
   input  logic                  load,
   input  logic                  err_clr,
   output logic [WIDTH-1:0]      bus_out,
   output logic                  bus_valid,
   output logic [IDXW-1:0]       src_idx,
   output logic                  sel_err
`ifdef BUS_MUX_ERR_CNT_EN
   ,
   output logic [ERR_CNT_W-1:0]  err_cnt
`endif
);

   logic [WIDTH-1:0] src_arr [NSRC];
   logic [IDXW-1:0]  hot_idx;
   logic [IDXW-1:0]  pick_idx;
   logic             legal;
   logic             illegal_load;

   logic [WIDTH-1:0] bus_reg, bus_next;
   logic             valid_reg, valid_next;
   logic [IDXW-1:0]  idx_reg, idx_next;
   logic             err_reg, err_next;

   generate
      if (NSRC < 2 || DEFAULT_IDX < 0 || DEFAULT_IDX >= NSRC || ERR_CNT_W < 1) begin : g_param_check
         $error("bus_mux_onehot_reg: illegal parameter combination");
      end
      for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
         assign src_arr[gi] = src_flat[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
   assign legal        = (sel != '0) && ((sel & (sel - NSRC'(1))) == '0);
   assign illegal_load = load && !legal;

   // OR of set-bit positions; exact whenever the select is one-hot.
   always_comb begin
      hot_idx = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (sel[i]) hot_idx = hot_idx | IDXW'(i);
      end
   end

   assign pick_idx = legal ? hot_idx : IDXW'(DEFAULT_IDX);

   always_comb begin
      bus_next   = bus_reg;
      valid_next = valid_reg;
      idx_next   = idx_reg;
      err_next   = err_reg;
      if (load) begin
         bus_next   = src_arr[pick_idx];
         idx_next   = pick_idx;
         valid_next = legal;
      end
      if (illegal_load) err_next = 1'b1;
      else if (err_clr) err_next = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus_reg   <= '0;
         valid_reg <= 1'b0;
         idx_reg   <= '0;
         err_reg   <= 1'b0;
      end else begin
         bus_reg   <= bus_next;
         valid_reg <= valid_next;
         idx_reg   <= idx_next;
         err_reg   <= err_next;
      end
   end

   assign bus_out   = bus_reg;
   assign bus_valid = valid_reg;
   assign src_idx   = idx_reg;
   assign sel_err   = err_reg;

`ifdef BUS_MUX_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] cnt_reg, cnt_next;

   // A clear on the same edge as an illegal load restarts the count at one.
   always_comb begin
      cnt_next = cnt_reg;
      if (illegal_load) begin
         if (err_clr)              cnt_next = ERR_CNT_W'(1);
         else if (cnt_reg != '1)   cnt_next = cnt_reg + ERR_CNT_W'(1);
      end else if (err_clr) begin
         cnt_next = '0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) cnt_reg <= '0;
      else         cnt_reg <= cnt_next;
   end

   assign err_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_bus_mux_onehot_reg.sv
// Self-checking bench for bus_mux_onehot_reg: directed scenarios plus randomized traffic
// against a popcount-based reference model, on a 9x10 and a 16x4 (ERR_CNT_W=2) instance.
`timescale 1ns/1ps
module tb_bus_mux_onehot_reg;

   localparam int AW = 9;
   localparam int AN = 10;
   localparam int BW = 16;
   localparam int BN = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic resetn;

   logic [AW*AN-1:0] a_src;
   logic [AN-1:0]    a_sel;
   logic             a_load, a_clr;
   logic [AW-1:0]    a_bus;
   logic             a_valid;
   logic [3:0]       a_idx;
   logic             a_err;

   logic [BW*BN-1:0] b_src;
   logic [BN-1:0]    b_sel;
   logic             b_load, b_clr;
   logic [BW-1:0]    b_bus;
   logic             b_valid;
   logic [1:0]       b_idx;
   logic             b_err;

`ifdef BUS_MUX_ERR_CNT_EN
   logic [7:0] a_cnt;
   logic [1:0] b_cnt;
`endif

   bus_mux_onehot_reg #(.WIDTH(AW), .NSRC(AN), .DEFAULT_IDX(0), .ERR_CNT_W(8)) dut_a (
      .clk(clk), .resetn(resetn), .src_flat(a_src), .sel(a_sel), .load(a_load),
      .err_clr(a_clr), .bus_out(a_bus), .bus_valid(a_valid), .src_idx(a_idx),
      .sel_err(a_err)
`ifdef BUS_MUX_ERR_CNT_EN
      , .err_cnt(a_cnt)
`endif
   );

   bus_mux_onehot_reg #(.WIDTH(BW), .NSRC(BN), .DEFAULT_IDX(0), .ERR_CNT_W(2)) dut_b (
      .clk(clk), .resetn(resetn), .src_flat(b_src), .sel(b_sel), .load(b_load),
      .err_clr(b_clr), .bus_out(b_bus), .bus_valid(b_valid), .src_idx(b_idx),
      .sel_err(b_err)
`ifdef BUS_MUX_ERR_CNT_EN
      , .err_cnt(b_cnt)
`endif
   );

   int n_total = 0;
   int n_pass  = 0;

   // Reference model state: what the registered outputs should hold.
   logic [AW-1:0] ma_bus;
   logic          ma_valid, ma_err;
   int            ma_idx, ma_cnt;
   logic [BW-1:0] mb_bus;
   logic          mb_valid, mb_err;
   int            mb_idx, mb_cnt;

   task automatic model_reset();
      ma_bus = '0; ma_valid = 1'b0; ma_err = 1'b0; ma_idx = 0; ma_cnt = 0;
      mb_bus = '0; mb_valid = 1'b0; mb_err = 1'b0; mb_idx = 0; mb_cnt = 0;
   endtask

   // Drive one transaction to instance A, advance one edge, update the model.
   task automatic step_a(input logic [AN-1:0] sel, input logic load, input logic clr);
      int pc;
      int pos;
      a_sel = sel; a_load = load; a_clr = clr;
      @(posedge clk);
      pc = 0; pos = 0;
      for (int i = 0; i < AN; i++) if (sel[i]) begin pc++; pos = i; end
      if (load) begin
         if (pc == 1) begin ma_bus = a_src[pos*AW +: AW]; ma_idx = pos; ma_valid = 1'b1; end
         else         begin ma_bus = a_src[0 +: AW];      ma_idx = 0;   ma_valid = 1'b0; end
      end
      if (load && pc != 1) begin
         ma_err = 1'b1;
         ma_cnt = clr ? 1 : ((ma_cnt < 255) ? ma_cnt + 1 : 255);
      end else if (clr) begin
         ma_err = 1'b0; ma_cnt = 0;
      end
      #1;
      $display("A sel=%b load=%b clr=%b -> bus=%h idx=%0d valid=%b err=%b",
               sel, load, clr, a_bus, a_idx, a_valid, a_err);
   endtask

   task automatic step_b(input logic [BN-1:0] sel, input logic load, input logic clr);
      int pc;
      int pos;
      b_sel = sel; b_load = load; b_clr = clr;
      @(posedge clk);
      pc = 0; pos = 0;
      for (int i = 0; i < BN; i++) if (sel[i]) begin pc++; pos = i; end
      if (load) begin
         if (pc == 1) begin mb_bus = b_src[pos*BW +: BW]; mb_idx = pos; mb_valid = 1'b1; end
         else         begin mb_bus = b_src[0 +: BW];      mb_idx = 0;   mb_valid = 1'b0; end
      end
      if (load && pc != 1) begin
         mb_err = 1'b1;
         mb_cnt = clr ? 1 : ((mb_cnt < 3) ? mb_cnt + 1 : 3);
      end else if (clr) begin
         mb_err = 1'b0; mb_cnt = 0;
      end
      #1;
      $display("B sel=%b load=%b clr=%b -> bus=%h idx=%0d valid=%b err=%b",
               sel, load, clr, b_bus, b_idx, b_valid, b_err);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      a_sel = '0; a_load = 1'b1; a_clr = 1'b0; a_src = {AN{9'h1FF}};
      b_sel = '0; b_load = 1'b1; b_clr = 1'b0; b_src = {BN{16'hFFFF}};
      #17;
      n_total++;
      if ({a_bus, a_valid, a_idx, a_err, b_bus, b_valid, b_idx, b_err} !== '0)
         $display("FAIL reset: got A bus=%h valid=%b idx=%0d err=%b B bus=%h valid=%b idx=%0d err=%b, want all zero",
                  a_bus, a_valid, a_idx, a_err, b_bus, b_valid, b_idx, b_err);
      else n_pass++;
`ifdef BUS_MUX_ERR_CNT_EN
      n_total++;
      if (a_cnt !== 8'd0 || b_cnt !== 2'd0)
         $display("FAIL reset_cnt: got a_cnt=%0d b_cnt=%0d, want 0 0", a_cnt, b_cnt);
      else n_pass++;
`endif
      a_load = 1'b0; b_load = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      model_reset();
      $display("reset released");
   endtask

   task automatic test_legal_load();
      a_src = '0;
      a_src[2*AW +: AW] = 9'h1A5;
      step_a(10'b0000000100, 1'b1, 1'b0);
      n_total++;
      if (a_bus !== 9'h1A5 || a_idx !== 4'd2 || a_valid !== 1'b1 || a_err !== 1'b0)
         $display("FAIL legal_load: got bus=%h idx=%0d valid=%b err=%b, want 1a5 2 1 0",
                  a_bus, a_idx, a_valid, a_err);
      else n_pass++;
   endtask

   task automatic test_hold();
      a_src[1*AW +: AW] = 9'h0F0;
      step_a(10'b0000000010, 1'b1, 1'b0);
      a_src[1*AW +: AW] = 9'h111;
      for (int k = 0; k < 3; k++) begin
         step_a(AN'($urandom), 1'b0, 1'b0);
         n_total++;
         if (a_bus !== 9'h0F0 || a_idx !== 4'd1 || a_valid !== 1'b1 || a_err !== 1'b0)
            $display("FAIL hold_%0d: got bus=%h idx=%0d valid=%b err=%b, want 0f0 1 1 0",
                     k, a_bus, a_idx, a_valid, a_err);
         else n_pass++;
      end
   endtask

   task automatic test_illegal();
      a_src[0 +: AW] = 9'h033;
      a_src[7*AW +: AW] = 9'h0C7;
      step_a(10'b0000000000, 1'b1, 1'b0);
      n_total++;
      if (a_bus !== 9'h033 || a_idx !== 4'd0 || a_valid !== 1'b0 || a_err !== 1'b1)
         $display("FAIL illegal_zero: got bus=%h idx=%0d valid=%b err=%b, want 033 0 0 1",
                  a_bus, a_idx, a_valid, a_err);
      else n_pass++;
      step_a(10'b0010000000, 1'b1, 1'b0);
      n_total++;
      if (a_bus !== 9'h0C7 || a_idx !== 4'd7 || a_valid !== 1'b1 || a_err !== 1'b1)
         $display("FAIL sticky_err: got bus=%h idx=%0d valid=%b err=%b, want 0c7 7 1 1",
                  a_bus, a_idx, a_valid, a_err);
      else n_pass++;
      step_a(10'b0000000000, 1'b0, 1'b1);
      n_total++;
      if (a_valid !== 1'b1 || a_err !== 1'b0 || a_bus !== 9'h0C7)
         $display("FAIL clr_valid: got bus=%h valid=%b err=%b, want 0c7 1 0", a_bus, a_valid, a_err);
      else n_pass++;
   endtask

   task automatic test_set_wins();
      step_a(10'b1000000001, 1'b1, 1'b1);
      n_total++;
      if (a_bus !== 9'h033 || a_idx !== 4'd0 || a_valid !== 1'b0 || a_err !== 1'b1)
         $display("FAIL set_wins: got bus=%h idx=%0d valid=%b err=%b, want 033 0 0 1",
                  a_bus, a_idx, a_valid, a_err);
      else n_pass++;
`ifdef BUS_MUX_ERR_CNT_EN
      n_total++;
      if (a_cnt !== 8'd1)
         $display("FAIL set_wins_cnt: got %0d, want 1", a_cnt);
      else n_pass++;
`endif
      step_a(10'b1111111111, 1'b0, 1'b1);
      n_total++;
      if (a_err !== 1'b0 || a_valid !== 1'b0 || a_bus !== 9'h033)
         $display("FAIL clear_fault: got bus=%h valid=%b err=%b, want 033 0 0", a_bus, a_valid, a_err);
      else n_pass++;
`ifdef BUS_MUX_ERR_CNT_EN
      n_total++;
      if (a_cnt !== 8'd0)
         $display("FAIL clear_cnt: got %0d, want 0", a_cnt);
      else n_pass++;
`endif
   endtask

   task automatic test_saturate();
      int exp_seq [5] = '{1, 2, 3, 3, 3};
      b_src = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      for (int k = 0; k < 5; k++) begin
         step_b(4'b0011, 1'b1, 1'b0);
         n_total++;
         if (b_err !== 1'b1 || b_valid !== 1'b0 || b_bus !== 16'h1111 || b_idx !== 2'd0)
            $display("FAIL sat_state_%0d: got bus=%h idx=%0d valid=%b err=%b, want 1111 0 0 1",
                     k, b_bus, b_idx, b_valid, b_err);
         else n_pass++;
`ifdef BUS_MUX_ERR_CNT_EN
         n_total++;
         if (b_cnt !== exp_seq[k][1:0])
            $display("FAIL sat_cnt_%0d: got %0d, want %0d", k, b_cnt, exp_seq[k]);
         else n_pass++;
`endif
      end
      step_b(4'b0000, 1'b0, 1'b1);
   endtask

   task automatic test_param();
      b_src = {16'hBEEF, 16'hCAFE, 16'h1234, 16'h5678};
      step_b(4'b1000, 1'b1, 1'b0);
      n_total++;
      if (b_bus !== 16'hBEEF || b_idx !== 2'd3 || b_valid !== 1'b1 || b_err !== 1'b0)
         $display("FAIL param_idx3: got bus=%h idx=%0d valid=%b err=%b, want beef 3 1 0",
                  b_bus, b_idx, b_valid, b_err);
      else n_pass++;
      step_b(4'b0100, 1'b1, 1'b0);
      n_total++;
      if (b_bus !== 16'hCAFE || b_idx !== 2'd2 || b_valid !== 1'b1)
         $display("FAIL param_idx2: got bus=%h idx=%0d valid=%b, want cafe 2 1", b_bus, b_idx, b_valid);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      a_src[4*AW +: AW] = 9'h15A;
      step_a(10'b0000010000, 1'b1, 1'b0);
      step_a(10'b0000000000, 1'b1, 1'b0);
      step_a(10'b0000010000, 1'b1, 1'b0);
      a_load = 1'b0; b_load = 1'b0;
      #3;
      resetn = 1'b0;
      #1;
      n_total++;
      if ({a_bus, a_valid, a_idx, a_err, b_bus, b_valid, b_idx, b_err} !== '0)
         $display("FAIL async_reset: got A bus=%h valid=%b idx=%0d err=%b B bus=%h valid=%b, want all zero",
                  a_bus, a_valid, a_idx, a_err, b_bus, b_valid);
      else n_pass++;
`ifdef BUS_MUX_ERR_CNT_EN
      n_total++;
      if (a_cnt !== 8'd0)
         $display("FAIL async_reset_cnt: got %0d, want 0", a_cnt);
      else n_pass++;
`endif
      @(posedge clk); #1;
      resetn = 1'b1;
      model_reset();
      $display("async reset applied and released");
   endtask

   function automatic logic [AN-1:0] rand_sel_a();
      logic [AN-1:0] s;
      s = '0;
      case ($urandom_range(0, 3))
         0:       s = '0;
         1:       s = AN'($urandom);
         default: s[$urandom_range(0, AN-1)] = 1'b1;
      endcase
      return s;
   endfunction

   function automatic logic [BN-1:0] rand_sel_b();
      logic [BN-1:0] s;
      s = '0;
      case ($urandom_range(0, 3))
         0:       s = '0;
         1:       s = BN'($urandom);
         default: s[$urandom_range(0, BN-1)] = 1'b1;
      endcase
      return s;
   endfunction

   task automatic test_random();
      for (int k = 0; k < 120; k++) begin
         for (int i = 0; i < AN; i++) a_src[i*AW +: AW] = AW'($urandom);
         step_a(rand_sel_a(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0));
         n_total++;
         if (a_bus !== ma_bus || a_idx !== ma_idx[3:0] || a_valid !== ma_valid || a_err !== ma_err)
            $display("FAIL rand_a_%0d: got bus=%h idx=%0d valid=%b err=%b, want %h %0d %b %b",
                     k, a_bus, a_idx, a_valid, a_err, ma_bus, ma_idx, ma_valid, ma_err);
         else n_pass++;
`ifdef BUS_MUX_ERR_CNT_EN
         n_total++;
         if (a_cnt !== ma_cnt[7:0])
            $display("FAIL rand_a_cnt_%0d: got %0d, want %0d", k, a_cnt, ma_cnt);
         else n_pass++;
`endif
         for (int i = 0; i < BN; i++) b_src[i*BW +: BW] = BW'($urandom);
         step_b(rand_sel_b(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0));
         n_total++;
         if (b_bus !== mb_bus || b_idx !== mb_idx[1:0] || b_valid !== mb_valid || b_err !== mb_err)
            $display("FAIL rand_b_%0d: got bus=%h idx=%0d valid=%b err=%b, want %h %0d %b %b",
                     k, b_bus, b_idx, b_valid, b_err, mb_bus, mb_idx, mb_valid, mb_err);
         else n_pass++;
`ifdef BUS_MUX_ERR_CNT_EN
         n_total++;
         if (b_cnt !== mb_cnt[1:0])
            $display("FAIL rand_b_cnt_%0d: got %0d, want %0d", k, b_cnt, mb_cnt);
         else n_pass++;
`endif
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_legal_load();
      test_hold();
      test_illegal();
      test_set_wins();
      test_saturate();
      test_param();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
